instr_mem_responder: RTL and testbench

- Responder end of the instruction-fetch interface: accepts word fetch requests from the fetch stage and returns instruction words in order.
- Backed by an internal word array of DEPTH entries, with a fixed access latency and a bounded number of outstanding requests.
- Includes a program-load write port so benches and boot logic can preload code.
- Sits between fetch_stage and the instruction storage.

---
 rtl/instr_mem_responder_pkg.sv | 29 ++
 rtl/instr_mem_responder_if.sv | 45 ++++
 rtl/imem_resp_fifo.sv | 80 ++++++++
 rtl/instr_mem_responder.sv | 159 +++++++++++++++
 tb/tb_instr_mem_responder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_responder_pkg
// Shared RISC-V widths and the instruction-fetch response type used by the
// instruction memory responder and by fetch_stage.
//   RISCV_ADDR_WIDTH : byte address width of the fetch bus
//   RISCV_WORD_WIDTH : instruction word width
//   imem_resp_t      : one fetch response {data, err}
//   make_resp        : builds a response, forcing data to zero on a fault
// ---------------------------------------------------------------------------
package instr_mem_responder_pkg;

    localparam int RISCV_ADDR_WIDTH = 32;
    localparam int RISCV_WORD_WIDTH = 32;

    typedef struct packed {
        logic [RISCV_WORD_WIDTH-1:0] data;
        logic                        err;
    } imem_resp_t;

    // A faulting access never leaks array contents onto the bus.
    function automatic imem_resp_t make_resp(input logic [RISCV_WORD_WIDTH-1:0] data,
                                             input logic                        err);
        imem_resp_t r;
        r.data = err ? '0 : data;
        r.err  = err;
        return r;
    endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// ---------------------------------------------------------------------------
// instr_mem_responder_if
// Instruction-fetch request/response bus between fetch_stage (master) and
// the instruction memory responder (slave). Signal suffixes are written from
// the responder's point of view.
//   instr_req_i    : fetch request valid                  (master -> slave)
//   instr_addr_i   : byte address of the requested word   (master -> slave)
//   instr_gnt_o    : request accepted this cycle          (slave -> master)
//   instr_rvalid_o : response valid                       (slave -> master)
//   instr_rdata_o  : instruction word                     (slave -> master)
//   instr_err_o    : response is an access fault          (slave -> master)
//   instr_rready_i : requester consumes the response      (master -> slave)
// ---------------------------------------------------------------------------
interface instr_mem_responder_if;
    import instr_mem_responder_pkg::*;

    logic                        instr_req_i;
    logic [RISCV_ADDR_WIDTH-1:0] instr_addr_i;
    logic                        instr_gnt_o;
    logic                        instr_rvalid_o;
    logic [RISCV_WORD_WIDTH-1:0] instr_rdata_o;
    logic                        instr_err_o;
    logic                        instr_rready_i;

    modport master (
        output instr_req_i,
        output instr_addr_i,
        output instr_rready_i,
        input  instr_gnt_o,
        input  instr_rvalid_o,
        input  instr_rdata_o,
        input  instr_err_o
    );

    modport slave (
        input  instr_req_i,
        input  instr_addr_i,
        input  instr_rready_i,
        output instr_gnt_o,
        output instr_rvalid_o,
        output instr_rdata_o,
        output instr_err_o
    );

endinterface

// File: rtl/imem_resp_fifo.sv
// ---------------------------------------------------------------------------
// imem_resp_fifo
// Synchronous circular FIFO holding fetch responses until the requester
// consumes them. Push and pop may occur in the same cycle, including when
// full. The head entry is presented combinationally and stays stable until
// popped.
//   clk, rst_n : clock, synchronous active-low reset (control state only)
//   i_push     : write i_data at the tail
//   i_data     : element to write
//   i_pop      : drop the head entry (ignored when empty)
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_head     : oldest entry
// ---------------------------------------------------------------------------
module imem_resp_fifo
    import instr_mem_responder_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = imem_resp_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output T     o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LP_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(DEPTH);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == LP_FULL);
    assign w_do_pop  = i_pop && !o_empty;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // The outstanding-request bound upstream must make overflow unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && o_full && !i_pop));

endmodule

// File: rtl/instr_mem_responder.sv
// ---------------------------------------------------------------------------
// instr_mem_responder
// Responder end of the instruction-fetch bus. Accepts word fetches, reads a
// DEPTH-word array on the grant cycle, carries the result down a LATENCY
// deep pipeline and returns responses in grant order through a FIFO sized to
// the outstanding-request limit. A load port preloads the array.
//   clk         : clock
//   rst_n       : synchronous active-low reset (array contents kept)
//   bus         : instruction-fetch bus, slave side
//   load_we_i   : array write enable
//   load_addr_i : word index to write
//   load_data_i : write data
// ---------------------------------------------------------------------------
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter int                          DEPTH           = 1024,
    parameter logic [RISCV_ADDR_WIDTH-1:0] BASE_ADDR       = 32'h0000_0000,
    parameter int                          LATENCY         = 2,
    parameter int                          MAX_OUTSTANDING = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    instr_mem_responder_if.slave        bus,
    input  logic                        load_we_i,
    input  logic [$clog2(DEPTH)-1:0]    load_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] load_data_i
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]          LP_MAX_OUT = CNT_W'(MAX_OUTSTANDING);
    // Byte span of the array, one bit wider so DEPTH*4 never truncates.
    localparam logic [RISCV_ADDR_WIDTH:0] LP_SPAN    = {1'b0, RISCV_ADDR_WIDTH'(DEPTH)} << 2;

    logic [RISCV_WORD_WIDTH-1:0] r_array [DEPTH];
    logic                        r_init_done;
    logic [CNT_W-1:0]            r_outstanding;

    logic                        w_rvalid;
    logic                        w_pop;
    logic                        w_gnt;
    logic [RISCV_ADDR_WIDTH-1:0] w_off;
    logic                        w_fault;
    logic [IDX_W-1:0]            w_idx;
    imem_resp_t                  w_resp_p0;
    imem_resp_t                  w_push_resp;
    logic                        w_push_vld;
    imem_resp_t                  w_head;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;

    // r_init_done keeps gnt low for the first cycle after reset releases.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= 1'b1;
        end
    end

    // Outputs are forced idle while reset is asserted, before the reset edge
    // has cleared the FIFO.
    assign w_rvalid = rst_n && !w_fifo_empty;
    assign w_pop    = w_rvalid && bus.instr_rready_i;
    assign w_gnt    = rst_n && r_init_done && bus.instr_req_i &&
                      ((r_outstanding < LP_MAX_OUT) || w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else begin
            case ({w_gnt, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Program-load port; a same-cycle fetch still sees the old word because
    // the read below is combinational on the pre-edge array.
    always_ff @(posedge clk) begin
        if (load_we_i) begin
            r_array[load_addr_i] <= load_data_i;
        end
    end

    // ---- stage p0: grant cycle, address decode and array read ----
    // Addresses below BASE_ADDR wrap w_off to a large value, but are also
    // caught explicitly.
    assign w_off     = bus.instr_addr_i - BASE_ADDR;
    assign w_fault   = (bus.instr_addr_i[1:0] != 2'b00) ||
                       (bus.instr_addr_i < BASE_ADDR) ||
                       ({1'b0, w_off} >= LP_SPAN);
    assign w_idx     = w_off[2 +: IDX_W];
    assign w_resp_p0 = make_resp(r_array[w_idx], w_fault);

    // ---- stages p1..p(LATENCY-1): delay line; the FIFO write is the last stage ----
    generate
        if (LATENCY == 1) begin : g_lat1
            assign w_push_vld  = w_gnt;
            assign w_push_resp = w_resp_p0;
        end else begin : g_pipe
            logic       r_vld_pipe  [LATENCY-1];
            imem_resp_t r_resp_pipe [LATENCY-1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        r_vld_pipe[i] <= 1'b0;
                    end
                end else begin
                    r_vld_pipe[0] <= w_gnt;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        r_vld_pipe[i] <= r_vld_pipe[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_resp_pipe[0] <= w_resp_p0;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    r_resp_pipe[i] <= r_resp_pipe[i-1];
                end
            end

            assign w_push_vld  = r_vld_pipe[LATENCY-2];
            assign w_push_resp = r_resp_pipe[LATENCY-2];
        end
    endgenerate

    // ---- stage p(LATENCY): response FIFO ----
    imem_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (imem_resp_t)
    ) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_vld),
        .i_data  (w_push_resp),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    assign bus.instr_gnt_o    = w_gnt;
    assign bus.instr_rvalid_o = w_rvalid;
    assign bus.instr_rdata_o  = w_rvalid ? w_head.data : '0;
    assign bus.instr_err_o    = w_rvalid && w_head.err;

    // A full FIFO can only mean every outstanding request is waiting in it.
    a_full_bound: assert property (@(posedge clk) disable iff (!rst_n)
        w_fifo_full |-> (r_outstanding == LP_MAX_OUT));
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        r_outstanding <= LP_MAX_OUT);

endmodule

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_we = 1'b0;
    logic [9:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] words [4];

    instr_mem_responder_if bus();

    instr_mem_responder #(
        .DEPTH           (1024),
        .BASE_ADDR       (32'h0000_0000),
        .LATENCY         (2),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .load_we_i   (load_we),
        .load_addr_i (load_addr),
        .load_data_i (load_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.instr_req_i    = 1'b1;
        bus.instr_addr_i   = 32'h0;
        bus.instr_rready_i = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        #1;
        checks++; if (bus.instr_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_gnt got %0b exp 0", bus.instr_gnt_o); end
        checks++; if (bus.instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %0b exp 0", bus.instr_rvalid_o); end
        checks++; if (bus.instr_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.instr_rdata_o); end
        checks++; if (bus.instr_err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", bus.instr_err_o); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.instr_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_first_gnt got %0b exp 0", bus.instr_gnt_o); end
        checks++; if (bus.instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_first_rvalid got %0b exp 0", bus.instr_rvalid_o); end
        step();
        bus.instr_req_i = 1'b0;
    endtask

    task automatic preload();
        for (int i = 0; i < 4; i++) begin
            load_we   = 1'b1;
            load_addr = 10'(i);
            load_data = words[i];
            step();
        end
        load_we = 1'b0;
    endtask

    task automatic test_single();
        bus.instr_req_i    = 1'b1;
        bus.instr_addr_i   = 32'h0;
        bus.instr_rready_i = 1'b1;
        #1;
        checks++; if (bus.instr_gnt_o !== 1'b1) begin errors++; $display("FAIL single_gnt got %0b exp 1", bus.instr_gnt_o); end
        checks++; if (bus.instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL single_rvalid_c0 got %0b exp 0", bus.instr_rvalid_o); end
        step();
        bus.instr_req_i = 1'b0;
        #1;
        checks++; if (bus.instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL single_rvalid_c1 got %0b exp 0", bus.instr_rvalid_o); end
        step();
        #1;
        checks++; if ({bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o} !== {1'b1, 1'b0, words[0]})
            begin errors++; $display("FAIL single_resp got v=%0b e=%0b d=%h exp v=1 e=0 d=%h", bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o, words[0]); end
        step();
        #1;
        checks++; if ({bus.instr_rvalid_o, bus.instr_rdata_o} !== {1'b0, 32'h0})
            begin errors++; $display("FAIL single_idle got v=%0b d=%h exp v=0 d=0", bus.instr_rvalid_o, bus.instr_rdata_o); end
    endtask

    task automatic test_stream();
        bus.instr_rready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.instr_req_i  = (k < 4);
            bus.instr_addr_i = 32'(4 * (k % 4));
            #1;
            if (k < 4) begin
                checks++; if (bus.instr_gnt_o !== 1'b1) begin errors++; $display("FAIL stream_gnt[%0d] got %0b exp 1", k, bus.instr_gnt_o); end
            end
            if (k >= 2) begin
                checks++; if ({bus.instr_rvalid_o, bus.instr_rdata_o} !== {1'b1, words[k-2]})
                    begin errors++; $display("FAIL stream_resp[%0d] got v=%0b d=%h exp v=1 d=%h", k, bus.instr_rvalid_o, bus.instr_rdata_o, words[k-2]); end
            end else begin
                checks++; if (bus.instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL stream_early[%0d] got %0b exp 0", k, bus.instr_rvalid_o); end
            end
            step();
        end
        #1;
        checks++; if (bus.instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL stream_tail got %0b exp 0", bus.instr_rvalid_o); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q [$];
        int          next_w = 0;
        int          guard = 0;
        bus.instr_rready_i = 1'b0;
        bus.instr_req_i    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.instr_addr_i = 32'(4 * next_w);
            #1;
            checks++; if (bus.instr_gnt_o !== (k < 4)) begin errors++; $display("FAIL bp_gnt[%0d] got %0b exp %0b", k, bus.instr_gnt_o, (k < 4)); end
            if (k < 4) begin
                exp_q.push_back(words[next_w]);
                next_w = (next_w + 1) % 4;
            end
            step();
        end
        bus.instr_rready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.instr_addr_i = 32'(4 * next_w);
            #1;
            checks++; if ({bus.instr_rvalid_o, bus.instr_rdata_o} !== {1'b1, exp_q[0]})
                begin errors++; $display("FAIL bp_pop[%0d] got v=%0b d=%h exp v=1 d=%h", k, bus.instr_rvalid_o, bus.instr_rdata_o, exp_q[0]); end
            checks++; if (bus.instr_gnt_o !== 1'b1) begin errors++; $display("FAIL bp_popgnt[%0d] got %0b exp 1", k, bus.instr_gnt_o); end
            void'(exp_q.pop_front());
            exp_q.push_back(words[next_w]);
            next_w = (next_w + 1) % 4;
            step();
        end
        bus.instr_req_i = 1'b0;
        while (exp_q.size() > 0 && guard < 12) begin
            #1;
            if (bus.instr_rvalid_o === 1'b1) begin
                checks++; if (bus.instr_rdata_o !== exp_q[0])
                    begin errors++; $display("FAIL bp_drain got %h exp %h", bus.instr_rdata_o, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            step();
            guard++;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain_timeout left %0d exp 0", exp_q.size()); end
        #1;
        checks++; if (bus.instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b exp 0", bus.instr_rvalid_o); end
    endtask

    task automatic test_faults();
        logic [31:0] addrs [3];
        logic [31:0] edata [3];
        logic        eerr  [3];
        addrs[0] = 32'h0000_0002; edata[0] = 32'h0;     eerr[0] = 1'b1;
        addrs[1] = 32'h0000_1000; edata[1] = 32'h0;     eerr[1] = 1'b1;
        addrs[2] = 32'h0000_0008; edata[2] = words[2];  eerr[2] = 1'b0;
        bus.instr_rready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.instr_req_i  = (k < 3);
            bus.instr_addr_i = addrs[k % 3];
            #1;
            if (k < 3) begin
                checks++; if (bus.instr_gnt_o !== 1'b1) begin errors++; $display("FAIL fault_gnt[%0d] got %0b exp 1", k, bus.instr_gnt_o); end
            end
            if (k >= 2) begin
                checks++; if ({bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o} !== {1'b1, eerr[k-2], edata[k-2]})
                    begin errors++; $display("FAIL fault_resp[%0d] got v=%0b e=%0b d=%h exp v=1 e=%0b d=%h", k, bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o, eerr[k-2], edata[k-2]); end
            end
            step();
        end
    endtask

    task automatic test_load_collision();
        logic [31:0] edata [2];
        edata[0] = words[1];
        edata[1] = 32'hDEAD_BEEF;
        bus.instr_rready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.instr_req_i  = (k < 2);
            bus.instr_addr_i = 32'h0000_0004;
            load_we   = (k == 0);
            load_addr = 10'd1;
            load_data = 32'hDEAD_BEEF;
            #1;
            if (k < 2) begin
                checks++; if (bus.instr_gnt_o !== 1'b1) begin errors++; $display("FAIL coll_gnt[%0d] got %0b exp 1", k, bus.instr_gnt_o); end
            end else begin
                checks++; if ({bus.instr_rvalid_o, bus.instr_rdata_o} !== {1'b1, edata[k-2]})
                    begin errors++; $display("FAIL coll_resp[%0d] got v=%0b d=%h exp v=1 d=%h", k, bus.instr_rvalid_o, bus.instr_rdata_o, edata[k-2]); end
            end
            step();
        end
        load_we  = 1'b0;
        words[1] = 32'hDEAD_BEEF;
    endtask

    task automatic test_mid_reset();
        bus.instr_rready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.instr_req_i  = 1'b1;
            bus.instr_addr_i = 32'(4 * k);
            #1;
            checks++; if (bus.instr_gnt_o !== 1'b1) begin errors++; $display("FAIL mr_gnt[%0d] got %0b exp 1", k, bus.instr_gnt_o); end
            step();
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.instr_gnt_o !== 1'b0) begin errors++; $display("FAIL mr_rst_gnt got %0b exp 0", bus.instr_gnt_o); end
        checks++; if (bus.instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL mr_rst_rvalid got %0b exp 0", bus.instr_rvalid_o); end
        step();
        rst_n = 1'b1;
        bus.instr_rready_i = 1'b1;
        bus.instr_addr_i   = 32'h0000_0008;
        #1;
        checks++; if (bus.instr_gnt_o !== 1'b0) begin errors++; $display("FAIL mr_first_gnt got %0b exp 0", bus.instr_gnt_o); end
        checks++; if (bus.instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL mr_first_rvalid got %0b exp 0", bus.instr_rvalid_o); end
        step();
        bus.instr_req_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (bus.instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL mr_stale[%0d] got %0b exp 0", k, bus.instr_rvalid_o); end
            step();
        end
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0000_0008;
        #1;
        checks++; if (bus.instr_gnt_o !== 1'b1) begin errors++; $display("FAIL mr_new_gnt got %0b exp 1", bus.instr_gnt_o); end
        step();
        bus.instr_req_i = 1'b0;
        #1;
        checks++; if (bus.instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL mr_new_early got %0b exp 0", bus.instr_rvalid_o); end
        step();
        #1;
        checks++; if ({bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o} !== {1'b1, 1'b0, words[2]})
            begin errors++; $display("FAIL mr_new_resp got v=%0b e=%0b d=%h exp v=1 e=0 d=%h", bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o, words[2]); end
        step();
    endtask

    initial begin
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        words[2] = 32'h0020_0113;
        words[3] = 32'h0030_0193;
        bus.instr_req_i    = 1'b0;
        bus.instr_addr_i   = 32'h0;
        bus.instr_rready_i = 1'b0;
        test_reset();
        preload();
        test_single();
        test_stream();
        test_backpressure();
        test_faults();
        test_load_collision();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
